// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative 32x32 -> 64-bit shift-and-add multiplier.
// One multiplier bit is consumed per clock; constant 34-cycle turnaround
// (accept, 32 busy cycles, done) regardless of operands or mode.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   a, b       32-bit multiplicand / multiplier, sampled on acceptance
//   is_signed  1 = two's-complement operands, 0 = unsigned; sampled on acceptance
//   start      level request, acted on only in IDLE
//   s          64-bit product register, holds last completed result
//   en         one-cycle strobe, high while s carries a freshly written result
module seq_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  input  logic        start,
  output logic [63:0] s,
  output logic        en
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [63:0] mcand;   // shifted multiplicand
  logic [31:0] mplier;  // shifted multiplier
  logic [63:0] acc;
  logic [5:0]  cnt;
  logic        neg;

  logic [31:0] a_mag, b_mag;
  logic [63:0] acc_nxt;
  logic        last_bit;

  // Magnitudes are kept as unsigned 32-bit values: |0x80000000| = 2^31
  // still fits, so no extra magnitude bit is needed.
  always_comb begin
    a_mag = (is_signed && a[31]) ? (~a + 32'd1) : a;
    b_mag = (is_signed && b[31]) ? (~b + 32'd1) : b;
  end

  always_comb begin
    acc_nxt  = mplier[0] ? (acc + mcand) : acc;
    last_bit = (cnt == 6'd31);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = BUSY;
      BUSY: if (last_bit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      s      <= '0;
      en     <= 1'b0;
    end else begin
      en <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mcand  <= {32'd0, a_mag};
          mplier <= b_mag;
          neg    <= is_signed & (a[31] ^ b[31]);
          acc    <= '0;
          cnt    <= '0;
        end
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 6'd1;
          // Result is written on the same edge that enters DONE, using the
          // final accumulation directly so en lines up with the state.
          if (last_bit) begin
            s  <= neg ? (~acc_nxt + 64'd1) : acc_nxt;
            en <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        is_signed;
  logic        start;
  logic [63:0] s;
  logic        en;

  int errors = 0;
  int checks = 0;
  int lat;
  int en_cnt;

  seq_multiplier dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .is_signed(is_signed),
    .start(start), .s(s), .en(en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for en after an acceptance edge; lat counts edges.
  task automatic wait_en(input logic [63:0] prev, output bit moved);
    moved = 1'b0;
    lat = 0;
    while (!en && lat < 40) begin
      if (s !== prev) moved = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input logic [63:0] exp, input bit scramble);
    logic [63:0] prev;
    bit moved;
    @(negedge clk);
    a = ta; b = tb_; is_signed = ts; start = 1'b1;
    prev = s;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin
      a = $urandom; b = $urandom; is_signed = ~ts;
    end
    wait_en(prev, moved);
    chk({tag, " latency"}, 64'(lat), 64'd32);
    chk({tag, " s"}, s, exp);
    chk({tag, " s held before en"}, {63'd0, moved}, 64'd0);
    @(posedge clk); #1;
    chk({tag, " en width"}, {63'd0, en}, 64'd0);
    chk({tag, " s hold"}, s, exp);
  endtask

  initial begin
    bit moved;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset s", s, 64'd0);
    chk("reset en", {63'd0, en}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op("u ffff*ffff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b0);
    run_op("s -1*-1",     32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h0000000000000001, 1'b0);
    run_op("s -1*2",      32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFFFFFFFFFE, 1'b0);
    run_op("u ffff*2",    32'hFFFFFFFF, 32'h00000002, 1'b0, 64'h00000001FFFFFFFE, 1'b0);
    run_op("s min*min",   32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b0);
    run_op("s min*1",     32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000, 1'b0);
    run_op("s 0*-1",      32'h00000000, 32'hFFFFFFFF, 1'b1, 64'h0000000000000000, 1'b0);
    run_op("u 7*9 scramble", 32'h00000007, 32'h00000009, 1'b0, 64'd63, 1'b1);

    // start held high; mode flips right after acceptance
    @(negedge clk);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    is_signed = 1'b1;
    wait_en(s, moved);
    chk("cont first latency", 64'(lat), 64'd32);
    chk("cont first s", s, 64'hFFFFFFFE00000001);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!en && lat < 40);
    start = 1'b0;
    chk("cont period", 64'(lat), 64'd34);
    chk("cont second s", s, 64'h0000000000000001);
    @(posedge clk); #1;
    chk("cont en width", {63'd0, en}, 64'd0);
    repeat (2) @(posedge clk);

    // reset in the middle of BUSY
    @(negedge clk);
    a = 32'h00001234; b = 32'h00005678; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid-reset s", s, 64'd0);
    chk("mid-reset en", {63'd0, en}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    en_cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (en) en_cnt++;
    end
    chk("no en after abort", 64'(en_cnt), 64'd0);
    chk("s stays 0 after abort", s, 64'd0);

    run_op("u 3*5 after reset", 32'd3, 32'd5, 1'b0, 64'd15, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
